// File: rtl/imem_dmem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package imem_dmem_arb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = 4;

  localparam logic [BEW-1:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Request fields presented on the memory port while a transaction is open.
  typedef struct packed {
    logic            we;
    logic [BEW-1:0]  be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of data grants taken while fetch was left waiting.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CW'(MAX));

  // Clear wins over increment; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and the
// memory stage: data has priority, fetch is protected from starvation, and a
// fetch kill drops an in-flight instruction response.
module imem_dmem_arbiter
  import imem_dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 if_req_i,
  input  logic [XLEN-1:0]      if_addr_i,
  input  logic                 if_kill_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [XLEN-1:0]      if_rdata_o,

  input  logic                 d_req_i,
  input  logic                 d_we_i,
  input  logic [BEW-1:0]       d_be_i,
  input  logic [XLEN-1:0]      d_addr_i,
  input  logic [XLEN-1:0]      d_wdata_i,
  output logic                 d_gnt_o,
  output logic                 d_rvalid_o,
  output logic [XLEN-1:0]      d_rdata_o,

  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [BEW-1:0]       mem_be_o,
  output logic [XLEN-1:0]      mem_addr_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [XLEN-1:0]      mem_rdata_i,

  output logic                 busy_o
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic       kill_q, kill_d;
  mem_req_t   mreq_q, mreq_d;

  logic starve_at_max;
  logic starve_inc;
  logic starve_clr;

  // Fetch gets a guaranteed slot once data has won STARVE_MAX times in a row.
  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .at_max_o (starve_at_max)
  );

  assign starve_inc = d_gnt_o && if_req_i;
  assign starve_clr = if_gnt_o;

  // Arbitration, transaction sequencing and response routing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    mreq_d      = mreq_q;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;

    case (state_q)
      IDLE: begin
        // Grants are combinational, so keep them quiet while reset is held.
        if (!rst_i) begin
          if (d_req_i && (!if_req_i || !starve_at_max)) begin
            d_gnt_o      = 1'b1;
            owner_d      = OWN_D;
            kill_d       = 1'b0;
            mreq_d.we    = d_we_i;
            mreq_d.be    = d_be_i;
            mreq_d.addr  = d_addr_i;
            mreq_d.wdata = d_wdata_i;
            state_d      = REQ;
          end else if (if_req_i && !if_kill_i) begin
            if_gnt_o     = 1'b1;
            owner_d      = OWN_IF;
            kill_d       = 1'b0;
            mreq_d.we    = 1'b0;
            mreq_d.be    = BE_ALL;
            mreq_d.addr  = if_addr_i;
            mreq_d.wdata = '0;
            state_d      = REQ;
          end
        end
      end

      REQ: begin
        if (owner_q == OWN_IF && if_kill_i) begin
          kill_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (owner_q == OWN_IF && if_kill_i) begin
          kill_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_o = 1'b1;
          end else if (!kill_q && !if_kill_i) begin
            if_rvalid_o = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, owner, kill flag and captured request fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_D;
      kill_q  <= 1'b0;
      mreq_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      mreq_q  <= mreq_d;
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign busy_o      = (state_q != IDLE);
  assign mem_we_o    = mreq_q.we;
  assign mem_be_o    = mreq_q.be;
  assign mem_addr_o  = mreq_q.addr;
  assign mem_wdata_o = mreq_q.wdata;

  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule
